// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC selection with redirect priority, pending-redirect
//               capture across stalls, RUN/HALT control and activity counters.
// Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic [31:0] pc_4,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        exc,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] pc_new,
   output logic        pc_en,
   output logic        halted,
   output logic [31:0] adv_cnt,
   output logic [15:0] stall_cnt
);

   localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_pend_valid;
   logic        w_pend_valid_nxt;
   logic [31:0] r_pend_target;
   logic [31:0] w_pend_target_nxt;
   logic [31:0] r_adv_cnt;
   logic [15:0] r_stall_cnt;

   logic        w_adv;
   logic        w_redir;
   logic [31:0] w_redir_tgt;
   logic        w_pc_en;
   logic [31:0] w_pc_new;

   // The next PC is built from pc_4 only; pc is carried for interface symmetry.
   logic        w_unused;
   assign w_unused = ^pc;

   always_comb begin
      w_adv   = !stall && imem_ready;
      w_redir = exc || jr || jmp || br_taken;
      if (exc)
         w_redir_tgt = EXC_VECTOR;
      else if (jr)
         w_redir_tgt = jr_target;
      else if (jmp)
         w_redir_tgt = jmp_target;
      else
         w_redir_tgt = br_target;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_pc_en           = 1'b0;
      w_pc_new          = pc_4;
      w_pend_valid_nxt  = r_pend_valid;
      w_pend_target_nxt = r_pend_target;

      case (r_state)
         RUN: begin
            w_pc_en = w_adv;
            if (w_redir)
               w_pc_new = w_redir_tgt;
            else if (r_pend_valid)
               w_pc_new = r_pend_target;

            if (w_adv) begin
               w_pend_valid_nxt = 1'b0;
            end else if (w_redir) begin
               w_pend_valid_nxt  = 1'b1;
               w_pend_target_nxt = w_redir_tgt;
            end

            if (halt_req)
               w_state_nxt = HALT;
         end

         HALT: begin
            // Only an exception may move the PC while halted; branches are dropped.
            if (exc) begin
               w_pc_en          = 1'b1;
               w_pc_new         = EXC_VECTOR;
               w_pend_valid_nxt = 1'b0;
               w_state_nxt      = RUN;
            end else begin
               if (r_pend_valid)
                  w_pc_new = r_pend_target;
               if (resume)
                  w_state_nxt = RUN;
            end
         end

         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_pend_valid  <= 1'b0;
         r_pend_target <= 32'h0;
      end else begin
         r_state       <= w_state_nxt;
         r_pend_valid  <= w_pend_valid_nxt;
         r_pend_target <= w_pend_target_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_adv_cnt   <= 32'h0;
         r_stall_cnt <= 16'h0;
      end else begin
         if (w_pc_en)
            r_adv_cnt <= r_adv_cnt + 32'd1;
         if ((r_state == RUN) && !w_pc_en && (r_stall_cnt != c_STALL_MAX))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   // Reset gates the outputs directly so the PC register stops without a clock.
   assign pc_en     = rst_n && w_pc_en;
   assign pc_new    = rst_n ? w_pc_new : pc_4;
   assign halted    = (r_state == HALT);
   assign adv_cnt   = r_adv_cnt;
   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
